// File: rtl/ac_frame_sequencer.sv
// ac_frame_sequencer
//   Per-frame control FSM between the CRF and the upsampler streaming datapath.
//   A rising edge on UPSTR[0] arms one frame. The block then gates source pixels
//   into the datapath and tracks the source and destination pixel/line positions.
//   It generates the tlast/tuser sideband for the output stream and checks the
//   tlast framing of the input stream. At the end of the frame it writes a
//   status word to UPENDR through the CRF write port.
//
// Ports
//   clk, rst       clock; asynchronous active-high reset
//   crf_ac_UPSTR   control register: bit0 start, bit1 abort
//   crf_ac_wbusy   CRF busy with an AXI-lite write; the write strobe is held meanwhile
//   ac_crf_wrt     CRF write strobe
//   ac_crf_waddr   CRF write address
//   ac_crf_wdata   CRF write data
//   in_fire        source pixel handshake this cycle
//   in_tlast       tlast of the source pixel; only used with in_fire
//   out_fire       destination pixel handshake this cycle
//   in_allow       source tready qualifier into the datapath
//   out_tlast      destination end-of-line
//   out_tuser      destination start-of-frame
//   busy           a frame is in progress (RUN, DRAIN, WB)
//
// Status word written to UPENDR:
//   bit0 done, bit1 err_tlast, bit2 aborted, bit3 err_order
module ac_frame_sequencer #(
  parameter int CRF_DATA_WIDTH = 32,
  parameter int CRF_ADDR_WIDTH = 4,
  parameter int UPENDR_ADDR    = 1,
  parameter int SRC_IMG_WIDTH  = 960,
  parameter int SRC_IMG_HEIGHT = 540,
  parameter int DST_IMG_WIDTH  = 3840,
  parameter int DST_IMG_HEIGHT = 2160
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CRF_DATA_WIDTH-1:0] crf_ac_UPSTR,
  input  logic                      crf_ac_wbusy,
  output logic                      ac_crf_wrt,
  output logic [CRF_ADDR_WIDTH-1:0] ac_crf_waddr,
  output logic [CRF_DATA_WIDTH-1:0] ac_crf_wdata,
  input  logic                      in_fire,
  input  logic                      in_tlast,
  input  logic                      out_fire,
  output logic                      in_allow,
  output logic                      out_tlast,
  output logic                      out_tuser,
  output logic                      busy
);

  localparam int unsigned IXW = (SRC_IMG_WIDTH  > 1) ? $clog2(SRC_IMG_WIDTH)  : 1;
  localparam int unsigned IYW = (SRC_IMG_HEIGHT > 1) ? $clog2(SRC_IMG_HEIGHT) : 1;
  localparam int unsigned OXW = (DST_IMG_WIDTH  > 1) ? $clog2(DST_IMG_WIDTH)  : 1;
  localparam int unsigned OYW = (DST_IMG_HEIGHT > 1) ? $clog2(DST_IMG_HEIGHT) : 1;

  localparam logic [IXW-1:0] IX_LAST = IXW'(SRC_IMG_WIDTH  - 1);
  localparam logic [IYW-1:0] IY_LAST = IYW'(SRC_IMG_HEIGHT - 1);
  localparam logic [OXW-1:0] OX_LAST = OXW'(DST_IMG_WIDTH  - 1);
  localparam logic [OYW-1:0] OY_LAST = OYW'(DST_IMG_HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_WB,
    S_DONE
  } state_t;

  state_t state;

  logic           start_q;
  logic [IXW-1:0] in_x;
  logic [IYW-1:0] in_y;
  logic [OXW-1:0] out_x;
  logic [OYW-1:0] out_y;
  logic           err_tlast;
  logic           err_order;
  logic           aborted;

  logic                      active;
  logic                      abort_req;
  logic                      in_acc;
  logic                      out_acc;
  logic                      in_x_last;
  logic                      in_last;
  logic                      out_x_last;
  logic                      out_last;
  logic                      err_tlast_nxt;
  logic                      err_order_nxt;
  logic                      aborted_nxt;
  logic [CRF_DATA_WIDTH-1:0] status_nxt;

  // Only the start and abort bits of UPSTR are meaningful here.
  logic unused_upstr_bits;
  assign unused_upstr_bits = ^crf_ac_UPSTR[CRF_DATA_WIDTH-1:2];

  always_comb begin
    active     = (state == S_RUN) || (state == S_DRAIN);
    abort_req  = active && crf_ac_UPSTR[1];
    // Abort removes tready in the same cycle, before the state changes.
    in_allow   = (state == S_RUN) && !crf_ac_UPSTR[1];
    in_acc     = in_fire && in_allow;
    out_acc    = out_fire && active;
    in_x_last  = (in_x == IX_LAST);
    in_last    = in_x_last && (in_y == IY_LAST);
    out_x_last = (out_x == OX_LAST);
    out_last   = out_x_last && (out_y == OY_LAST);

    out_tlast  = active && out_x_last;
    out_tuser  = active && (out_x == '0) && (out_y == '0);
    busy       = active || (state == S_WB);

    err_tlast_nxt = err_tlast || (in_acc && (in_tlast != in_x_last));
    // Outputs completing in the same cycle as the last input is still in order.
    err_order_nxt = err_order || ((state == S_RUN) && out_acc && out_last &&
                                  !abort_req && !(in_acc && in_last));
    aborted_nxt   = aborted || abort_req;

    // The status word is built from next-state flags so the registered write
    // data already reflects an error detected in the cycle that enters WB.
    status_nxt    = '0;
    status_nxt[0] = 1'b1;
    status_nxt[1] = err_tlast_nxt;
    status_nxt[2] = aborted_nxt;
    status_nxt[3] = err_order_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      start_q      <= 1'b0;
      in_x         <= '0;
      in_y         <= '0;
      out_x        <= '0;
      out_y        <= '0;
      err_tlast    <= 1'b0;
      err_order    <= 1'b0;
      aborted      <= 1'b0;
      ac_crf_wrt   <= 1'b0;
      ac_crf_waddr <= '0;
      ac_crf_wdata <= '0;
    end else begin
      start_q <= crf_ac_UPSTR[0];

      case (state)
        S_IDLE: begin
          if (crf_ac_UPSTR[0] && !start_q) begin
            state     <= S_RUN;
            in_x      <= '0;
            in_y      <= '0;
            out_x     <= '0;
            out_y     <= '0;
            err_tlast <= 1'b0;
            err_order <= 1'b0;
            aborted   <= 1'b0;
          end
        end

        S_RUN, S_DRAIN: begin
          if (in_acc) begin
            if (in_x_last) begin
              in_x <= '0;
              in_y <= in_y + IYW'(1);
            end else begin
              in_x <= in_x + IXW'(1);
            end
          end
          if (out_acc) begin
            if (out_x_last) begin
              out_x <= '0;
              out_y <= out_y + OYW'(1);
            end else begin
              out_x <= out_x + OXW'(1);
            end
          end

          err_tlast <= err_tlast_nxt;
          err_order <= err_order_nxt;
          aborted   <= aborted_nxt;

          if (abort_req || (out_acc && out_last)) begin
            state        <= S_WB;
            ac_crf_wrt   <= 1'b1;
            ac_crf_waddr <= CRF_ADDR_WIDTH'(UPENDR_ADDR);
            ac_crf_wdata <= status_nxt;
          end else if (in_acc && in_last) begin
            state <= S_DRAIN;
          end
        end

        S_WB: begin
          if (!crf_ac_wbusy) begin
            state        <= S_DONE;
            ac_crf_wrt   <= 1'b0;
            ac_crf_waddr <= '0;
            ac_crf_wdata <= '0;
          end
        end

        S_DONE: begin
          if (!crf_ac_UPSTR[0]) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ac_frame_sequencer.sv
module tb_ac_frame_sequencer;

  localparam int SW = 4;
  localparam int SH = 2;
  localparam int DW = 16;
  localparam int DH = 8;
  localparam int NIN  = SW * SH;
  localparam int NOUT = DW * DH;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] crf_ac_UPSTR = '0;
  logic        crf_ac_wbusy = 1'b0;
  logic        ac_crf_wrt;
  logic [3:0]  ac_crf_waddr;
  logic [31:0] ac_crf_wdata;
  logic        in_fire = 1'b0;
  logic        in_tlast = 1'b0;
  logic        out_fire = 1'b0;
  logic        in_allow;
  logic        out_tlast;
  logic        out_tuser;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  // Expected UPENDR writes, pushed when a frame is started.
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  ac_frame_sequencer #(
    .CRF_DATA_WIDTH(32),
    .CRF_ADDR_WIDTH(4),
    .UPENDR_ADDR(1),
    .SRC_IMG_WIDTH(SW),
    .SRC_IMG_HEIGHT(SH),
    .DST_IMG_WIDTH(DW),
    .DST_IMG_HEIGHT(DH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .crf_ac_UPSTR(crf_ac_UPSTR),
    .crf_ac_wbusy(crf_ac_wbusy),
    .ac_crf_wrt(ac_crf_wrt),
    .ac_crf_waddr(ac_crf_waddr),
    .ac_crf_wdata(ac_crf_wdata),
    .in_fire(in_fire),
    .in_tlast(in_tlast),
    .out_fire(out_fire),
    .in_allow(in_allow),
    .out_tlast(out_tlast),
    .out_tuser(out_tuser),
    .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Write monitor: every cycle the strobe is up, the write must match the head
  // of the scoreboard; the entry is retired on the cycle the CRF takes it.
  always @(negedge clk) begin
    if (!rst && ac_crf_wrt) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", {31'd0, ac_crf_wrt}, 32'd0);
      end else begin
        chk("wb_addr", {28'd0, ac_crf_waddr}, 32'd1);
        chk("wb_data", ac_crf_wdata, sb[0]);
        if (!crf_ac_wbusy) void'(sb.pop_front());
      end
    end
  end

  typedef struct {
    logic [7:0]  tlast_pat;  // in_tlast for source pixel i is bit i
    int          n_in;       // source pixels fed before the outputs
    int          abort_at;   // abort instead of source pixel index, -1 none
    int          wbusy;      // cycles of crf_ac_wbusy during WB
    logic        hold;       // keep UPSTR[0] high until well after DONE
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v);
    logic ab;
    ab = 1'b0;
    sb.push_back(v.exp_word);

    crf_ac_UPSTR = 32'd1;
    in_fire = 1'b0;
    out_fire = 1'b0;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_allow", {31'd0, in_allow}, 32'd0);
    adv();
    if (!v.hold) crf_ac_UPSTR = 32'd0;

    for (int i = 0; i < v.n_in; i++) begin
      if (i == v.abort_at) begin
        crf_ac_UPSTR = 32'd3;
        in_fire = 1'b0;
        in_tlast = 1'b0;
        @(negedge clk);
        chk("abort_allow", {31'd0, in_allow}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd1);
        adv();
        crf_ac_UPSTR = v.hold ? 32'd1 : 32'd0;
        ab = 1'b1;
        break;
      end
      in_fire = 1'b1;
      in_tlast = v.tlast_pat[i];
      @(negedge clk);
      chk("run_allow", {31'd0, in_allow}, 32'd1);
      chk("run_busy", {31'd0, busy}, 32'd1);
      chk("run_tuser", {31'd0, out_tuser}, 32'd1);
      adv();
    end
    in_fire = 1'b0;
    in_tlast = 1'b0;

    if (!ab) begin
      for (int k = 0; k < NOUT; k++) begin
        out_fire = 1'b1;
        // After all sources are in, extra in_fire with a wrong tlast must be ignored.
        in_fire = (v.n_in == NIN);
        in_tlast = (v.n_in == NIN);
        @(negedge clk);
        chk("out_allow", {31'd0, in_allow}, (v.n_in == NIN) ? 32'd0 : 32'd1);
        chk("out_tuser", {31'd0, out_tuser}, (k == 0) ? 32'd1 : 32'd0);
        chk("out_tlast", {31'd0, out_tlast}, ((k % DW) == DW - 1) ? 32'd1 : 32'd0);
        adv();
      end
      out_fire = 1'b0;
      in_fire = 1'b0;
      in_tlast = 1'b0;
    end

    crf_ac_wbusy = (v.wbusy > 0);
    for (int w = 0; w < v.wbusy; w++) begin
      @(negedge clk);
      chk("wb_held_wrt", {31'd0, ac_crf_wrt}, 32'd1);
      adv();
    end
    crf_ac_wbusy = 1'b0;
    @(negedge clk);
    chk("wb_wrt", {31'd0, ac_crf_wrt}, 32'd1);
    chk("wb_busy", {31'd0, busy}, 32'd1);
    adv();
    @(negedge clk);
    chk("done_wrt", {31'd0, ac_crf_wrt}, 32'd0);
    chk("done_busy", {31'd0, busy}, 32'd0);

    if (v.hold) begin
      for (int h = 0; h < 10; h++) begin
        adv();
        @(negedge clk);
        chk("hold_busy", {31'd0, busy}, 32'd0);
        chk("hold_allow", {31'd0, in_allow}, 32'd0);
      end
      crf_ac_UPSTR = 32'd0;
    end
    adv();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            pattern      n_in abort wbusy hold  word
    vecs[0] = '{8'b1000_1000, NIN,  -1,   0,   1'b0, 32'h1};  // clean frame
    vecs[1] = '{8'b1000_0100, NIN,  -1,   0,   1'b0, 32'h3};  // tlast on wrong pixel
    vecs[2] = '{8'b1000_1000, NIN,  -1,   5,   1'b0, 32'h1};  // CRF busy for 5 cycles
    vecs[3] = '{8'b1000_1000, NIN,   3,   2,   1'b0, 32'h5};  // abort after 3 pixels
    vecs[4] = '{8'b1000_1000, 0,    -1,   0,   1'b0, 32'h9};  // outputs finish first
    vecs[5] = '{8'b1000_1000, NIN,  -1,   0,   1'b1, 32'h1};  // start held through DONE
    vecs[6] = '{8'b1000_1000, NIN,  -1,   1,   1'b0, 32'h1};  // fresh frame after release

    #2;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_allow", {31'd0, in_allow}, 32'd0);
    chk("reset_wrt", {31'd0, ac_crf_wrt}, 32'd0);
    chk("reset_wdata", ac_crf_wdata, 32'd0);
    chk("reset_tuser", {31'd0, out_tuser}, 32'd0);
    adv();
    rst = 1'b0;
    adv();

    for (int v = 0; v < 7; v++) run_vec(vecs[v]);

    // Reset in the middle of the output phase: no write may appear.
    crf_ac_UPSTR = 32'd1;
    adv();
    crf_ac_UPSTR = 32'd0;
    for (int i = 0; i < NIN; i++) begin
      in_fire = 1'b1;
      in_tlast = (i % SW) == SW - 1;
      adv();
    end
    in_fire = 1'b0;
    in_tlast = 1'b0;
    for (int k = 0; k < 50; k++) begin
      out_fire = 1'b1;
      adv();
    end
    out_fire = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_allow", {31'd0, in_allow}, 32'd0);
    chk("rst_tlast", {31'd0, out_tlast}, 32'd0);
    chk("rst_tuser", {31'd0, out_tuser}, 32'd0);
    chk("rst_wrt", {31'd0, ac_crf_wrt}, 32'd0);
    chk("rst_waddr", {28'd0, ac_crf_waddr}, 32'd0);
    chk("rst_wdata", ac_crf_wdata, 32'd0);
    adv();
    adv();
    rst = 1'b0;
    adv();

    run_vec(vecs[0]);

    adv();
    chk("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
